md_issue_ctrl: RTL and testbench

- Pipeline-side initiator for the multiply/divide unit's start/busy interface.
- Sits in the E stage and accepts decoded mult/div/mthi/mtlo/mfhi/mflo ops.
- Drives operands and a one-cycle start pulse to the unit, and tracks the operation to completion.
- Owns the architectural HI/LO registers and produces the pipeline stall for every dependent md op.

---
 rtl/md_pkg.sv | 50 +++++
 rtl/md_issue_ctrl_if.sv | 25 ++
 rtl/md_hilo_regs.sv | 47 ++++
 rtl/md_issue_ctrl.sv | 120 ++++++++++++
 tb/tb_md_issue_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared types for the multiply/divide issue controller: op/func encodings,
// FSM states, the request payload sent to the unit, and default sizing.
package md_pkg;

    localparam int unsigned MD_DATA_W      = 32;
    localparam int unsigned MD_TIMEOUT_CYC = 64;
    localparam int unsigned MD_CNT_W       = 7;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_MF    = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        FN_MULT  = 2'd0,
        FN_MULTU = 2'd1,
        FN_DIV   = 2'd2,
        FN_DIVU  = 2'd3
    } md_func_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } md_state_t;

    typedef struct packed {
        logic [MD_DATA_W-1:0] data1;
        logic [MD_DATA_W-1:0] data2;
        md_func_t             func;
    } md_req_t;

    function automatic logic is_arith(md_op_t op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // MULT..DIVU are consecutive codes starting at 1, so func = code - 1
    function automatic md_func_t op2func(md_op_t op);
        logic [2:0] code;
        code = 3'(op) - 3'd1;
        return md_func_t'(code[1:0]);
    endfunction

endpackage

// File: rtl/md_issue_ctrl_if.sv
// Start/busy handshake between the issue controller (master) and the
// multiply/divide unit (slave).
interface md_issue_ctrl_if;
    import md_pkg::*;

    logic [MD_DATA_W-1:0] data1;
    logic [MD_DATA_W-1:0] data2;
    md_func_t             md_func;
    logic                 start;
    logic                 busy;
    logic                 md_done;
    logic [MD_DATA_W-1:0] md_hi;
    logic [MD_DATA_W-1:0] md_lo;

    modport master (
        output data1, data2, md_func, start,
        input  busy, md_done, md_hi, md_lo
    );

    modport slave (
        input  data1, data2, md_func, start,
        output busy, md_done, md_hi, md_lo
    );

endinterface

// File: rtl/md_hilo_regs.sv
// Architectural HI/LO pair: unit-result write, MTHI/MTLO write and the
// combinational MFHI/MFLO read mux.
module md_hilo_regs
    import md_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 mt_we,
    input  logic                 mt_lo,
    input  logic [MD_DATA_W-1:0] mt_data,
    input  logic                 done_we,
    input  logic [MD_DATA_W-1:0] done_hi,
    input  logic [MD_DATA_W-1:0] done_lo,
    input  logic                 rd_en,
    input  logic                 rd_lo,
    output logic [MD_DATA_W-1:0] rd_data_c
);

    logic [MD_DATA_W-1:0] hi_q, hi_d;
    logic [MD_DATA_W-1:0] lo_q, lo_d;

    // Done and mt writes are mutually exclusive by FSM state; done is listed first.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (done_we) begin
            hi_d = done_hi;
            lo_d = done_lo;
        end else if (mt_we) begin
            if (mt_lo) lo_d = mt_data;
            else       hi_d = mt_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign rd_data_c = !rd_en ? '0 : (rd_lo ? lo_q : hi_q);

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage initiator for the multiply/divide unit: issues ops, tracks them to
// completion, owns HI/LO and stalls dependent md ops. MD_TIMEOUT_EN adds a watchdog.
module md_issue_ctrl
    import md_pkg::*;
`ifdef MD_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYC = MD_TIMEOUT_CYC,
    parameter int unsigned CNT_W       = MD_CNT_W
)
`endif
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 op_valid,
    input  logic [2:0]           op_code,
    input  logic                 op_lo,
    input  logic [MD_DATA_W-1:0] rs_data,
    input  logic [MD_DATA_W-1:0] rt_data,
    output logic                 stall,
    output logic [MD_DATA_W-1:0] mf_data,
    md_issue_ctrl_if.master      md
`ifdef MD_TIMEOUT_EN
    ,
    output logic                 md_err
`endif
);

    md_op_t    op;
    md_state_t state_q, state_d;
    md_req_t   req_q, req_d;
    logic      start_q;
    logic      accept;
    logic      timeout;

    assign op = md_op_t'(op_code);

    // Decoded from registered state only, so ISSUE is covered before busy rises
    assign stall  = op_valid && (op != OP_NONE) && (state_q != ST_IDLE);
    assign accept = op_valid && (state_q == ST_IDLE) && is_arith(op);

`ifdef MD_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;

    assign timeout = (state_q == ST_BUSY) && !md.md_done &&
                     (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_d == ST_ISSUE)
            cnt_d = '0;
        else if ((state_q == ST_BUSY) && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_q | timeout;
        end
    end

    assign md_err = err_q;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_d   = '{data1: rs_data, data2: rt_data, func: op2func(op)};
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_BUSY;
            ST_BUSY: begin
                if (md.md_done || timeout) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            start_q <= (state_d == ST_ISSUE);
        end
    end

    assign md.data1   = req_q.data1;
    assign md.data2   = req_q.data2;
    assign md.md_func = req_q.func;
    assign md.start   = start_q;

    md_hilo_regs u_hilo (
        .clk       (clk),
        .reset_n   (reset_n),
        .mt_we     (op_valid && (state_q == ST_IDLE) && ((op == OP_MTHI) || (op == OP_MTLO))),
        .mt_lo     (op == OP_MTLO),
        .mt_data   (rs_data),
        .done_we   ((state_q == ST_BUSY) && md.md_done),
        .done_hi   (md.md_hi),
        .done_lo   (md.md_lo),
        .rd_en     (op_valid && (op == OP_MF)),
        .rd_lo     (op_lo),
        .rd_data_c (mf_data)
    );

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: stub mul/div unit, directed scenarios, then random ops
// checked against a cycle-count reference model. Define MD_TIMEOUT_EN for the watchdog case.
module tb_md_issue_ctrl;
    import md_pkg::*;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic        op_valid;
    logic [2:0]  op_code;
    logic        op_lo;
    logic [31:0] rs_data, rt_data;
    logic        stall;
    logic [31:0] mf_data;
    logic        stray;
    int unsigned next_lat;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    md_issue_ctrl_if md();

`ifdef MD_TIMEOUT_EN
    localparam int TMO = 8;
    logic md_err;
    md_issue_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(MD_CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_code(op_code), .op_lo(op_lo),
        .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .mf_data(mf_data), .md(md),
        .md_err(md_err));
`else
    md_issue_ctrl dut (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_code(op_code), .op_lo(op_lo),
        .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .mf_data(mf_data), .md(md));
`endif

    // Architectural result {HI, LO}; divide by zero returns HI=dividend, LO=all ones
    function automatic logic [63:0] md_ref(logic [1:0] fn, logic [31:0] a, logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (fn)
            2'd0: return 64'(sa * sb);
            2'd1: return {32'd0, a} * {32'd0, b};
            2'd2: return (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            default: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
        endcase
    endfunction

    // Stub unit: busy for next_lat cycles after start, done on the last; lat 0 = silent unit
    int unsigned u_left;
    logic [31:0] u_a, u_b;
    logic [1:0]  u_fn;
    logic [63:0] u_res;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            u_left <= 0; u_a <= '0; u_b <= '0; u_fn <= '0;
        end else if (md.start) begin
            u_left <= next_lat; u_a <= md.data1; u_b <= md.data2; u_fn <= md.md_func;
        end else if (u_left != 0) begin
            u_left <= u_left - 1;
        end
    end

    assign u_res      = md_ref(u_fn, u_a, u_b);
    assign md.busy    = (u_left != 0);
    assign md.md_done = (u_left == 1) || stray;
    assign md.md_hi   = u_res[63:32];
    assign md.md_lo   = u_res[31:0];

    task automatic check_eq(string tag, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding op, occupancy measured in cycles since accept
    logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
    logic [1:0]  m_fn = '0;
    bit          m_act = 1'b0, m_err = 1'b0;
    int          m_acc = 0, m_lat = 0, cyc = 0;

    function automatic int m_end();
`ifdef MD_TIMEOUT_EN
        return m_acc + 1 + ((m_lat == 0) ? TMO : m_lat);
`else
        return m_acc + 1 + m_lat;
`endif
    endfunction

    function automatic bit m_occ();
        return m_act && (cyc <= m_end());
    endfunction

    // Called just after a rising edge; drives one cycle, checks at negedge, advances model
    task automatic step(bit v, logic [2:0] c, bit lo, logic [31:0] a, logic [31:0] b,
                        bit sd, int lat);
        bit occ, exp_stall, exp_start;
        logic [2:0] f;
        op_valid = v; op_code = c; op_lo = lo; rs_data = a; rt_data = b; stray = sd;
        occ       = m_occ();
        exp_stall = v && (c != 3'd0) && occ;
        exp_start = m_act && (cyc == m_acc + 1);
        @(negedge clk);
        check_eq("stall", 32'(stall), 32'(exp_stall));
        check_eq("start", 32'(md.start), 32'(exp_start));
        if (!exp_stall)
            check_eq("mf_data", mf_data, (v && c == 3'd7) ? (lo ? m_lo : m_hi) : 32'd0);
        if (exp_start) begin
            check_eq("data1", md.data1, m_a);
            check_eq("data2", md.data2, m_b);
            check_eq("md_func", 32'(md.md_func), 32'(m_fn));
        end
`ifdef MD_TIMEOUT_EN
        check_eq("md_err", 32'(md_err), 32'(m_err));
`endif
        if (occ) begin
            if (cyc == m_end()) begin
                if (m_lat != 0) {m_hi, m_lo} = md_ref(m_fn, m_a, m_b);
                else            m_err = 1'b1;
                m_act = 1'b0;
            end
        end else if (v) begin
            if (c == 3'd5) m_hi = a;
            if (c == 3'd6) m_lo = a;
            if (c >= 3'd1 && c <= 3'd4) begin
                f = c - 3'd1;
                m_act = 1'b1; m_acc = cyc; m_lat = lat;
                m_a = a; m_b = b; m_fn = f[1:0];
                next_lat = lat;
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 3'd0, 0, '0, '0, 0, 1);
    endtask

    task automatic do_reset();
        op_valid = 1; op_code = 3'd7; op_lo = 0; rs_data = '0; rt_data = '0; stray = 0;
        reset_n = 0;
        #1;
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_start", 32'(md.start), 32'd0);
        check_eq("rst_data1", md.data1, 32'd0);
        check_eq("rst_data2", md.data2, 32'd0);
        check_eq("rst_func", 32'(md.md_func), 32'd0);
        check_eq("rst_mfhi", mf_data, 32'd0);
`ifdef MD_TIMEOUT_EN
        check_eq("rst_err", 32'(md_err), 32'd0);
`endif
        m_hi = '0; m_lo = '0; m_act = 1'b0; m_err = 1'b0;
        @(posedge clk); #1;
        reset_n = 1;
        cyc++;
    endtask

    initial begin
        bit          v, lo, sd;
        logic [2:0]  c;
        logic [31:0] a, b;
        next_lat = 1;
        op_valid = 0; op_code = '0; op_lo = 0; rs_data = '0; rt_data = '0; stray = 0;
        #2;
        do_reset();

        // MULT 3 * -2, unit takes 5 busy cycles, then MFLO
        step(1, 3'd1, 0, 32'd3, 32'hFFFF_FFFE, 0, 5);
        idle(6);
        step(1, 3'd7, 1, '0, '0, 0, 1);
        step(1, 3'd7, 0, '0, '0, 0, 1);

        // DIV with MFHI queued behind it: stalls through ISSUE and all BUSY cycles
        step(1, 3'd3, 0, 32'd100, 32'd7, 0, 3);
        for (int i = 0; i < 6; i++) step(1, 3'd7, 0, '0, '0, 0, 1);

        // MTHI then MFHI without stall
        step(1, 3'd5, 0, 32'h0000_1234, '0, 0, 1);
        step(1, 3'd7, 0, '0, '0, 0, 1);
        check_eq("mthi_const", m_hi, 32'h0000_1234);

        // DIVU by zero, then MFHI/MFLO
        step(1, 3'd4, 0, 32'h8000_0001, 32'd0, 0, 2);
        idle(3);
        step(1, 3'd7, 0, '0, '0, 0, 1);
        step(1, 3'd7, 1, '0, '0, 0, 1);

        // Stray done in IDLE must not disturb HI/LO
        step(0, 3'd0, 0, '0, '0, 1, 1);
        step(1, 3'd7, 1, '0, '0, 0, 1);

        // Reset while BUSY, then a late done is ignored
        step(1, 3'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 6);
        idle(3);
        do_reset();
        step(0, 3'd0, 0, '0, '0, 1, 1);
        step(1, 3'd7, 0, '0, '0, 0, 1);
        step(1, 3'd7, 1, '0, '0, 0, 1);

`ifdef MD_TIMEOUT_EN
        // Silent unit: watchdog aborts after TMO busy cycles, HI/LO untouched
        step(1, 3'd5, 0, 32'hCAFE_0001, '0, 0, 1);
        step(1, 3'd1, 0, 32'd9, 32'd9, 0, 0);
        for (int i = 0; i < TMO + 2; i++) step(1, 3'd7, 0, '0, '0, 0, 1);
        step(0, 3'd0, 0, '0, '0, 1, 1);
        step(1, 3'd7, 0, '0, '0, 0, 1);
        step(1, 3'd7, 1, '0, '0, 0, 1);
`endif

        // Random mix of all op codes
        for (int i = 0; i < 800; i++) begin
            v  = ($urandom % 4) != 0;
            c  = 3'($urandom % 8);
            lo = 1'($urandom % 2);
            a  = (($urandom % 4) == 0) ? (32'($urandom % 32) - 32'd16) : $urandom;
            b  = (($urandom % 8) == 0) ? 32'd0 :
                 ((($urandom % 4) == 0) ? (32'($urandom % 32) - 32'd16) : $urandom);
            sd = !m_occ() && (($urandom % 16) == 0);
            step(v, c, lo, a, b, sd, 1 + int'($urandom % 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
